instr_fetch: RTL

Fetch stage of the multicycle MIPS core: on a request from the main control FSM, reads one 32-bit instruction word from memory at the current PC and holds it in the instruction register. Presents the decoded fields (OP, Funct, register indices, immediates) to the control FSM and datapath. The control FSM consumes OP/Funct from this block. Flags misaligned fetches and, optionally, memory timeouts as faults for the exception logic (Cause/EPC).

---
 rtl/instr_fetch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Multicycle MIPS fetch stage: reads one instruction word into IR on request and decodes its fields.
// Optional memory timeout via `FETCH_TIMEOUT_EN` (default build: REQ waits indefinitely for mem_ack).
module instr_fetch #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        fetch_req,
    input  logic [31:0] PC,
    input  logic        instr_ready,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic        busy,
    output logic [5:0]  OP,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  Funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr,
    output logic        misaligned,
    output logic        timeout_fault
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;

    state_t      state;
    logic [31:0] ir;
    logic [31:0] addr;
    logic        accept;

    // A new request is taken from IDLE, or from HOLD when the held word is consumed in the same cycle.
    assign accept = fetch_req && ((state == IDLE) || ((state == HOLD) && instr_ready));

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt;
    logic       timeout_q;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            ir         <= '0;
            addr       <= '0;
            misaligned <= 1'b0;
            timeout_q  <= 1'b0;
            wait_cnt   <= '0;
        end else if (accept) begin
            addr     <= PC;
            wait_cnt <= '0;
            if (PC[1:0] != 2'b00) begin
                misaligned <= 1'b1;
                state      <= FAULT;
            end else begin
                state <= REQ;
            end
        end else begin
            case (state)
                REQ: begin
                    // An ack on the limit cycle still wins over the timeout.
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        state <= HOLD;
                    end else if (wait_cnt == LIMIT) begin
                        timeout_q <= 1'b1;
                        state     <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HOLD: if (instr_ready) state <= IDLE;
                FAULT: begin
                    if (instr_ready) begin
                        misaligned <= 1'b0;
                        timeout_q  <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign timeout_fault = timeout_q;
`else
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            ir         <= '0;
            addr       <= '0;
            misaligned <= 1'b0;
        end else if (accept) begin
            addr <= PC;
            if (PC[1:0] != 2'b00) begin
                misaligned <= 1'b1;
                state      <= FAULT;
            end else begin
                state <= REQ;
            end
        end else begin
            case (state)
                REQ: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        state <= HOLD;
                    end
                end
                HOLD: if (instr_ready) state <= IDLE;
                FAULT: begin
                    if (instr_ready) begin
                        misaligned <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign timeout_fault = 1'b0;
`endif

    assign mem_rd      = (state == REQ);
    assign mem_addr    = addr;
    assign instr_valid = (state == HOLD);
    assign busy        = (state != IDLE);

    assign OP    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign Funct = ir[5:0];
    assign imm16 = ir[15:0];
    assign jaddr = ir[25:0];

endmodule
